// File: rtl/led_pattern_pkg.sv
// Purpose: shared mode encodings, RNG seed and pattern helper functions for led_pattern_gen.
// Latency: n/a (constants and pure combinational functions only).
// Backpressure: n/a.
package led_pattern_pkg;

  localparam logic [1:0] MODE_GRAY    = 2'd0;
  localparam logic [1:0] MODE_RANDOM  = 2'd1;
  localparam logic [1:0] MODE_SCAN    = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  localparam logic [31:0] RNG_SEED = 32'h0001_0000;

  // Rule-30 cellular automaton on a 32-cell ring: new = left ^ (centre | right).
  function automatic logic [31:0] rule30_next(input logic [31:0] r);
    return {r[0], r[31:1]} ^ (r | {r[30:0], r[31]});
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Purpose: LOG2DELAY-bit step prescaler with pause hold, synchronous clear and registered tick.
// Latency: tick rises the cycle after the counter is all-ones; wrap is combinational in that cycle.
// Backpressure: pause holds the counter (no wrap, no tick); clr zeroes it and suppresses the tick.
// Ports: clk, rst_n (async low), pause, clr in; wrap (step-this-edge), tick (registered pulse) out.
module led_prescaler #(
  parameter int LOG2DELAY = 22
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause,
  input  logic clr,
  output logic wrap,
  output logic tick
);

  logic [LOG2DELAY-1:0] presc_q, presc_d;
  logic                 tick_q, tick_d;

  assign wrap = (&presc_q) & ~pause;
  assign tick = tick_q;

  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (clr) begin
      presc_d = '0;
    end else if (!pause) begin
      // all-ones + 1 wraps to zero naturally
      presc_d = presc_q + LOG2DELAY'(1);
      tick_d  = wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Purpose: four-mode LED pattern engine (gray count, rule-30 random, bounce scan, PWM breathe).
// Latency: pattern state steps on the tick edge; leds show the new pattern one cycle later.
// Backpressure: none; pause freezes stepping, leds keep refreshing and breathe PWM keeps running.
// Ports: clk, rst_n (async low), mode[1:0], pause in; leds[NUM_LEDS-1:0], tick out.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int LOG2DELAY = 22,
  parameter int PWM_BITS  = 8,
  parameter int RNG_LSB   = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] POS_BCK = POS_W'(NUM_LEDS - 2);
  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;

  logic [1:0]          mode_q, mode_d;
  logic [NUM_LEDS-1:0] bin_q, bin_d;
  logic [31:0]         rng_q, rng_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                scan_dn_q, scan_dn_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                br_dn_q, br_dn_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;

  logic mode_chg;
  logic wrap;
  logic step;

  assign mode_chg = (mode != mode_q);
  // A mode change outranks a coincident prescaler wrap.
  assign step     = wrap & ~mode_chg;

  led_prescaler #(.LOG2DELAY(LOG2DELAY)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .pause (pause),
    .clr   (mode_chg),
    .wrap  (wrap),
    .tick  (tick)
  );

  always_comb begin
    mode_d    = mode_q;
    bin_d     = bin_q;
    rng_d     = rng_q;
    pos_d     = pos_q;
    scan_dn_d = scan_dn_q;
    level_d   = level_q;
    br_dn_d   = br_dn_q;
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

    if (mode_chg) begin
      mode_d    = mode;
      bin_d     = '0;
      rng_d     = RNG_SEED;
      pos_d     = '0;
      scan_dn_d = 1'b0;
      level_d   = '0;
      br_dn_d   = 1'b0;
      pwm_cnt_d = '0;
    end else if (step) begin
      case (mode_q)
        MODE_GRAY:   bin_d = bin_q + NUM_LEDS'(1);
        MODE_RANDOM: rng_d = rule30_next(rng_q);
        MODE_SCAN: begin
          // Endpoints are visited once per bounce: turn around onto the neighbour.
          if (!scan_dn_q) begin
            if (pos_q == POS_MAX) begin
              scan_dn_d = 1'b1;
              pos_d     = POS_BCK;
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end else begin
            if (pos_q == '0) begin
              scan_dn_d = 1'b0;
              pos_d     = POS_W'(1);
            end else begin
              pos_d = pos_q - POS_W'(1);
            end
          end
        end
        default: begin
          if (!br_dn_q) begin
            if (level_q == LVL_MAX) begin
              br_dn_d = 1'b1;
              level_d = LVL_MAX - PWM_BITS'(1);
            end else begin
              level_d = level_q + PWM_BITS'(1);
            end
          end else begin
            if (level_q == '0) begin
              br_dn_d = 1'b0;
              level_d = PWM_BITS'(1);
            end else begin
              level_d = level_q - PWM_BITS'(1);
            end
          end
        end
      endcase
    end
  end

  // Output mux reads the registered state, so a step shows one cycle after tick.
  always_comb begin
    leds_d = '0;
    case (mode_q)
      MODE_GRAY:   leds_d = NUM_LEDS'(bin2gray(32'(bin_q)));
      MODE_RANDOM: leds_d = rng_q[RNG_LSB +: NUM_LEDS];
      MODE_SCAN:   leds_d = {{(NUM_LEDS-1){1'b0}}, 1'b1} << pos_q;
      default:     leds_d = {NUM_LEDS{pwm_cnt_q < level_q}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_GRAY;
      bin_q     <= '0;
      rng_q     <= RNG_SEED;
      pos_q     <= '0;
      scan_dn_q <= 1'b0;
      level_q   <= '0;
      br_dn_q   <= 1'b0;
      pwm_cnt_q <= '0;
      leds_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      bin_q     <= bin_d;
      rng_q     <= rng_d;
      pos_q     <= pos_d;
      scan_dn_q <= scan_dn_d;
      level_q   <= level_d;
      br_dn_q   <= br_dn_d;
      pwm_cnt_q <= pwm_cnt_d;
      leds_q    <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule
